// File: rtl/iter_div_if.sv
// rtl/iter_div_if.sv - operand/result handshake bundle for the iterative divider
interface iter_div_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_signed;
  logic [31:0] in_dividend;
  logic [31:0] in_divisor;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_quotient;
  logic [31:0] out_remainder;

  modport master (
    output in_valid, in_signed, in_dividend, in_divisor, out_ready,
    input  in_ready, out_valid, out_quotient, out_remainder
  );

  modport slave (
    input  in_valid, in_signed, in_dividend, in_divisor, out_ready,
    output in_ready, out_valid, out_quotient, out_remainder
  );
endinterface

// File: rtl/iter_div.sv
// rtl/iter_div.sv - radix-2 restoring 32-bit divider, one quotient bit per cycle
module iter_div (
  input  logic       clk,
  input  logic       reset,
  input  logic       cancel,
  iter_div_if.slave  dif
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [31:0] quo_q;
  logic [31:0] rem_q;
  logic [31:0] divisor_q;
  logic [31:0] dividend_raw_q;
  logic        sign_q_q;
  logic        sign_r_q;
  logic        dbz_q;
  logic [4:0]  cnt_q;

  logic        accept;
  logic [31:0] dividend_mag;
  logic [31:0] divisor_mag;
  logic [32:0] partial;
  logic [32:0] sub;
  logic        ge;

  assign accept = (state_q == IDLE) && dif.in_valid && !cancel;

  assign dividend_mag = (dif.in_signed && dif.in_dividend[31]) ? -dif.in_dividend : dif.in_dividend;
  assign divisor_mag  = (dif.in_signed && dif.in_divisor[31])  ? -dif.in_divisor  : dif.in_divisor;

  // A partial with bit 32 set always exceeds the 32-bit divisor; otherwise
  // the borrow out of the 33-bit subtract decides.
  assign partial = {rem_q, quo_q[31]};
  assign sub     = partial - {1'b0, divisor_q};
  assign ge      = partial[32] | ~sub[32];

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (dif.in_valid)       state_d = BUSY;
      BUSY:    if (cnt_q == 5'd31)     state_d = DONE;
      DONE:    if (dif.out_ready)      state_d = IDLE;
      default:                         state_d = IDLE;
    endcase
    if (cancel) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      quo_q          <= '0;
      rem_q          <= '0;
      divisor_q      <= '0;
      dividend_raw_q <= '0;
      sign_q_q       <= 1'b0;
      sign_r_q       <= 1'b0;
      dbz_q          <= 1'b0;
      cnt_q          <= '0;
    end else if (accept) begin
      quo_q          <= dividend_mag;
      rem_q          <= '0;
      divisor_q      <= divisor_mag;
      dividend_raw_q <= dif.in_dividend;
      sign_q_q       <= dif.in_signed & (dif.in_dividend[31] ^ dif.in_divisor[31]);
      sign_r_q       <= dif.in_signed & dif.in_dividend[31];
      dbz_q          <= (dif.in_divisor == 32'd0);
      cnt_q          <= '0;
    end else if (state_q == BUSY) begin
      quo_q <= {quo_q[30:0], ge};
      rem_q <= ge ? sub[31:0] : partial[31:0];
      cnt_q <= cnt_q + 5'd1;
    end
  end

  assign dif.in_ready  = (state_q == IDLE);
  assign dif.out_valid = (state_q == DONE);

  always_comb begin
    dif.out_quotient  = '0;
    dif.out_remainder = '0;
    if (state_q == DONE) begin
      if (dbz_q) begin
        dif.out_quotient  = 32'hFFFF_FFFF;
        dif.out_remainder = dividend_raw_q;
      end else begin
        dif.out_quotient  = sign_q_q ? -quo_q : quo_q;
        dif.out_remainder = sign_r_q ? -rem_q : rem_q;
      end
    end
  end

endmodule
